// File: rtl/alu_mul_seq.sv
// Sequential 8x8 unsigned multiply (low byte) built from the shared ALU's ADD and SHIFT ops.
// Optional MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module alu_mul_seq #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_result,
   output logic [WIDTH-1:0] o_aluA,
   output logic [WIDTH-1:0] o_aluB,
   output logic [1:0]       o_aluOp,
   output logic             o_aluSubShiftDir,
   output logic             o_aluWr,
   output logic             o_aluNoe,
   input  logic [WIDTH-1:0] i_aluY
);

   localparam int unsigned CNT_W    = 3;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(7);
   localparam logic [1:0]  OP_ADD   = 2'b00;
   localparam logic [1:0]  OP_SHIFT = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_TEST,
      S_ADD_EX,
      S_ADD_RD,
      S_SHL_EX,
      S_SHL_RD,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplr_q, mplr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   alu_a_q, alu_a_d;
   logic [WIDTH-1:0]   alu_b_q, alu_b_d;
   logic [1:0]         alu_op_q, alu_op_d;
   logic               alu_dir_q, alu_dir_d;
   logic               alu_wr_q, alu_wr_d;
   logic               alu_noe_q, alu_noe_d;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q   <= S_IDLE;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplr_q    <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_op_q  <= OP_ADD;
         alu_dir_q <= 1'b0;
         alu_wr_q  <= 1'b0;
         alu_noe_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplr_q    <= mplr_d;
         cnt_q     <= cnt_d;
         result_q  <= result_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         alu_a_q   <= alu_a_d;
         alu_b_q   <= alu_b_d;
         alu_op_q  <= alu_op_d;
         alu_dir_q <= alu_dir_d;
         alu_wr_q  <= alu_wr_d;
         alu_noe_q <= alu_noe_d;
      end
   end

   // Next state and datapath; outputs are registered from the state being entered.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplr_d    = mplr_q;
      cnt_d     = cnt_q;
      result_d  = result_q;
      alu_a_d   = alu_a_q;
      alu_b_d   = alu_b_q;
      alu_op_d  = alu_op_q;
      alu_dir_d = alu_dir_q;

      case (state_q)
         S_IDLE: begin
            if (i_start && !i_abort) begin
               acc_d   = '0;
               mcand_d = i_a;
               mplr_d  = i_b;
               cnt_d   = '0;
               state_d = S_TEST;
            end
         end
         S_TEST: begin
`ifdef MUL_EARLY_EXIT_EN
            if (mplr_q == '0)
               state_d = S_DONE;
            else
`endif
            if (mplr_q[0])
               state_d = S_ADD_EX;
            else if (cnt_q == CNT_LAST)
               state_d = S_DONE;
            else
               state_d = S_SHL_EX;
         end
         S_ADD_EX: state_d = S_ADD_RD;
         S_ADD_RD: begin
            acc_d   = i_aluY;
            state_d = (cnt_q == CNT_LAST) ? S_DONE : S_SHL_EX;
         end
         S_SHL_EX: state_d = S_SHL_RD;
         S_SHL_RD: begin
            mcand_d = i_aluY;
            mplr_d  = mplr_q >> 1;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = S_TEST;
         end
         S_DONE: begin
            result_d = acc_q;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (i_abort)
         state_d = S_IDLE;

      // Registered control for the state about to be entered.
      busy_d    = (state_d != S_IDLE);
      done_d    = (state_d == S_DONE);
      alu_wr_d  = (state_d == S_ADD_EX) || (state_d == S_SHL_EX);
      alu_noe_d = !((state_d == S_ADD_RD) || (state_d == S_SHL_RD));

      if (state_d == S_ADD_EX) begin
         alu_a_d   = acc_d;
         alu_b_d   = mcand_d;
         alu_op_d  = OP_ADD;
         alu_dir_d = 1'b0;
      end else if (state_d == S_SHL_EX) begin
         alu_a_d   = mcand_d;
         alu_b_d   = WIDTH'(1);
         alu_op_d  = OP_SHIFT;
         alu_dir_d = 1'b1;
      end
   end

   assign o_busy           = busy_q;
   assign o_done           = done_q;
   assign o_result         = result_q;
   assign o_aluA           = alu_a_q;
   assign o_aluB           = alu_b_q;
   assign o_aluOp          = alu_op_q;
   assign o_aluSubShiftDir = alu_dir_q;
   assign o_aluWr          = alu_wr_q;
   assign o_aluNoe         = alu_noe_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a behavioural registered-result ALU on the data bus.
module tb_alu_mul_seq;

   logic       clk = 1'b0;
   logic       i_reset, i_start, i_abort;
   logic [7:0] i_a, i_b, o_result, o_aluA, o_aluB, i_aluY;
   logic [1:0] o_aluOp;
   logic       o_busy, o_done, o_aluSubShiftDir, o_aluWr, o_aluNoe;

   always #5 clk = ~clk;

   alu_mul_seq #(.WIDTH(8)) dut (
      .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_abort(i_abort),
      .i_a(i_a), .i_b(i_b), .o_busy(o_busy), .o_done(o_done), .o_result(o_result),
      .o_aluA(o_aluA), .o_aluB(o_aluB), .o_aluOp(o_aluOp),
      .o_aluSubShiftDir(o_aluSubShiftDir), .o_aluWr(o_aluWr), .o_aluNoe(o_aluNoe),
      .i_aluY(i_aluY)
   );

   // ALU: result register written on o_aluWr, driven onto the bus only while o_aluNoe is low.
   logic [7:0] alu_r = 8'h00;
   always @(posedge clk) begin
      if (o_aluWr) begin
         case (o_aluOp)
            2'b00:   alu_r <= o_aluA + o_aluB;
            2'b11:   alu_r <= o_aluSubShiftDir ? (o_aluA << o_aluB[2:0]) : (o_aluA >> o_aluB[2:0]);
            default: alu_r <= 8'h00;
         endcase
      end
   end
   assign i_aluY = o_aluNoe ? 8'hA5 : alu_r;

   int add_cnt = 0, shl_cnt = 0, viol_cnt = 0, done_cnt = 0;
   always @(negedge clk) begin
      if (o_aluWr && o_aluOp == 2'b00) add_cnt <= add_cnt + 1;
      if (o_aluWr && o_aluOp == 2'b11) shl_cnt <= shl_cnt + 1;
      if (o_aluWr && !o_aluNoe)        viol_cnt <= viol_cnt + 1;
      if (o_done)                      done_cnt <= done_cnt + 1;
   end

   int n_vec = 0, n_err = 0;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Start one op in cycle 0; optional re-pulse of i_start in restart_cyc. Returns in cycle lat+1.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int restart_cyc,
                         output int lat, output int adds, output int shls,
                         output int viols, output int dones);
      int k, a0, s0, v0, d0;
      @(negedge clk);
      i_a = a; i_b = b; i_start = 1'b1;
      a0 = add_cnt; s0 = shl_cnt; v0 = viol_cnt; d0 = done_cnt;
      @(posedge clk); #1;
      i_start = 1'b0;
      k = 1; lat = -1;
      while (lat < 0 && k < 80) begin
         i_start = (k == restart_cyc);
         @(negedge clk);
         if (o_done) lat = k;
         @(posedge clk); #1;
         k++;
      end
      i_start = 1'b0;
      adds = add_cnt - a0; shls = shl_cnt - s0; viols = viol_cnt - v0; dones = done_cnt - d0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   typedef struct {
      logic [7:0] a, b, res;
      int lat, lat_ee, adds, shl, shl_ee;
   } vec_t;
   vec_t tv[10];

   initial begin
      int lat, adds, shls, viols, dones, d0, k, l1, l2;

      tv[0] = '{8'd5,   8'd3,   8'd15,  27, 12, 2, 7, 2};
      tv[1] = '{8'd255, 8'd255, 8'h01,  39, 39, 8, 7, 7};
      tv[2] = '{8'h10,  8'h10,  8'h00,  25, 19, 1, 7, 5};
      tv[3] = '{8'd7,   8'd0,   8'd0,   23,  2, 0, 7, 0};
      tv[4] = '{8'd13,  8'd11,  8'h8F,  29, 20, 3, 7, 4};
      tv[5] = '{8'h80,  8'h80,  8'h00,  25, 25, 1, 7, 7};
      tv[6] = '{8'd1,   8'h80,  8'h80,  25, 25, 1, 7, 7};
      tv[7] = '{8'd9,   8'h41,  8'h49,  27, 27, 2, 7, 7};
      tv[8] = '{8'hFF,  8'h02,  8'hFE,  25, 10, 1, 7, 2};
      tv[9] = '{8'd3,   8'd4,   8'd12,  25, 13, 1, 7, 3};

      i_reset = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_a = 8'h00; i_b = 8'h00;
      idle_cycles(3);
      i_reset = 1'b0;
      @(negedge clk);
      check("rst_busy",   int'(o_busy),   0);
      check("rst_done",   int'(o_done),   0);
      check("rst_noe",    int'(o_aluNoe), 1);
      check("rst_wr",     int'(o_aluWr),  0);
      check("rst_result", int'(o_result), 0);
      check("rst_aluA",   int'(o_aluA),   0);
      check("rst_aluOp",  int'(o_aluOp),  0);

      // Reset mid-operation: 7x9, i_reset in cycle 5
      @(negedge clk);
      i_a = 8'd7; i_b = 8'd9; i_start = 1'b1;
      d0 = done_cnt;
      @(posedge clk); #1;
      i_start = 1'b0;
      idle_cycles(4);
      check("midrst_busy_before", int'(o_busy), 1);
      i_reset = 1'b1;
      @(posedge clk); #1;
      i_reset = 1'b0;
      check("midrst_busy",   int'(o_busy),   0);
      check("midrst_noe",    int'(o_aluNoe), 1);
      check("midrst_wr",     int'(o_aluWr),  0);
      check("midrst_result", int'(o_result), 0);
      check("midrst_aluA",   int'(o_aluA),   0);
      check("midrst_done",   int'(o_done),   0);
      idle_cycles(30);
      check("midrst_no_done", done_cnt - d0, 0);

      for (int i = 0; i < 10; i++) begin
         run_op(tv[i].a, tv[i].b, -1, lat, adds, shls, viols, dones);
`ifdef MUL_EARLY_EXIT_EN
         check($sformatf("v%0d_latency", i), lat, tv[i].lat_ee);
         check($sformatf("v%0d_shifts", i), shls, tv[i].shl_ee);
`else
         check($sformatf("v%0d_latency", i), lat, tv[i].lat);
         check($sformatf("v%0d_shifts", i), shls, tv[i].shl);
`endif
         check($sformatf("v%0d_result", i), int'(o_result), int'(tv[i].res));
         check($sformatf("v%0d_adds", i), adds, tv[i].adds);
         check($sformatf("v%0d_noe_wr_overlap", i), viols, 0);
         check($sformatf("v%0d_done_pulses", i), dones, 1);
         check($sformatf("v%0d_done_after", i), int'(o_done), 0);
         check($sformatf("v%0d_busy_after", i), int'(o_busy), 0);
         idle_cycles(2);
      end

      // Second i_start in cycle 4 of 6x7 is ignored
      run_op(8'd6, 8'd7, 4, lat, adds, shls, viols, dones);
`ifdef MUL_EARLY_EXIT_EN
      check("restart_latency", lat, 17);
`else
      check("restart_latency", lat, 29);
`endif
      check("restart_result", int'(o_result), 42);
      check("restart_adds", adds, 3);
      check("restart_dones", dones, 1);
      idle_cycles(2);

      // Abort in cycle 3 of 2x2
      @(negedge clk);
      i_a = 8'd2; i_b = 8'd2; i_start = 1'b1;
      d0 = done_cnt;
      @(posedge clk); #1;
      i_start = 1'b0;
      idle_cycles(2);
      i_abort = 1'b1;
      @(posedge clk); #1;
      i_abort = 1'b0;
      check("abort_busy", int'(o_busy),   0);
      check("abort_noe",  int'(o_aluNoe), 1);
      check("abort_wr",   int'(o_aluWr),  0);
      idle_cycles(40);
      check("abort_no_done", done_cnt - d0, 0);
      check("abort_result",  int'(o_result), 42);

      // Abort together with start in IDLE: nothing starts
      @(negedge clk);
      i_a = 8'd9; i_b = 8'd9; i_start = 1'b1; i_abort = 1'b1;
      d0 = done_cnt;
      @(posedge clk); #1;
      i_start = 1'b0; i_abort = 1'b0;
      check("abortstart_busy", int'(o_busy), 0);
      idle_cycles(40);
      check("abortstart_no_done", done_cnt - d0, 0);
      check("abortstart_result", int'(o_result), 42);

      // Back-to-back with i_start held high: 3x4 then 2x5
      @(negedge clk);
      i_a = 8'd3; i_b = 8'd4; i_start = 1'b1;
      @(posedge clk); #1;
      i_a = 8'd2; i_b = 8'd5;
      k = 1; l1 = -1;
      while (l1 < 0 && k < 80) begin
         @(negedge clk);
         if (o_done) l1 = k;
         @(posedge clk); #1;
         k++;
      end
`ifdef MUL_EARLY_EXIT_EN
      check("b2b_lat1", l1, 13);
`else
      check("b2b_lat1", l1, 25);
`endif
      check("b2b_result1", int'(o_result), 12);
      check("b2b_idle_gap", int'(o_busy), 0);
      @(posedge clk); #1;
      i_start = 1'b0;
      check("b2b_second_accepted", int'(o_busy), 1);
      k = 1; l2 = -1;
      while (l2 < 0 && k < 80) begin
         @(negedge clk);
         if (o_done) l2 = k;
         @(posedge clk); #1;
         k++;
      end
`ifdef MUL_EARLY_EXIT_EN
      check("b2b_lat2", l2, 15);
`else
      check("b2b_lat2", l2, 27);
`endif
      check("b2b_result2", int'(o_result), 10);
      check("b2b_noe_wr_overlap", viol_cnt, 0);

      idle_cycles(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle controller that computes an unsigned 8x8 multiply, low byte only, by sequencing the shared 8-bit ALU.
- Uses the ALU's ADD and SHIFT operations in a shift-and-add loop.
- Drives the ALU operand and control lines, and reads the ALU's registered result back off the data bus.
- Sits beside the microcode control unit, which starts it and waits for o_done before releasing the ALU and bus.

Parameters:
- WIDTH, 8, operand/result width. Must match the ALU width; only 8 is supported.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_start  in  1  start request; sampled only in IDLE
- i_abort  in  1  cancel the running operation
- i_a  in  8  multiplicand, captured on start
- i_b  in  8  multiplier, captured on start
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse when the result is valid
- o_result  out  8  product low byte; held until the next accepted start
- o_aluA  out  8  ALU operand A
- o_aluB  out  8  ALU operand B
- o_aluOp  out  2  ALU op select: 00 ADD, 11 SHIFT
- o_aluSubShiftDir  out  1  ALU sub/shift-direction control
- o_aluWr  out  1  ALU result-register write enable
- o_aluNoe  out  1  ALU bus-driver enable, active low
- i_aluY  in  8  data bus value, valid while o_aluNoe=0

Behaviour:
- Clock/reset: one clock, i_clk. Reset i_reset is synchronous, active-high.
- Registers: r_acc, r_mcand, r_mplr (8 bit each), r_cnt (3 bit), state.
- Reset values: state=IDLE, all registers 0, o_result=0, o_busy=0, o_done=0, o_aluWr=0, o_aluNoe=1, o_aluA=0, o_aluB=0, o_aluOp=00, o_aluSubShiftDir=0.
- Outside the states that assign them, o_aluWr=0 and o_aluNoe=1. o_aluNoe is never 0 in the same cycle as o_aluWr=1.
- IDLE: on i_start, load r_acc=0, r_mcand=i_a, r_mplr=i_b, r_cnt=0, then go to TEST.
- TEST:
  - r_mplr[0]=1 -> ADD_EX.
  - Otherwise, r_cnt=7 -> DONE.
  - Otherwise -> SHL_EX.
- ADD_EX: A=r_acc, B=r_mcand, op=00, dir=0, wr=1 -> ADD_RD.
- ADD_RD: noe=0, r_acc<=i_aluY. Then r_cnt=7 -> DONE, else -> SHL_EX.
- SHL_EX: A=r_mcand, B=8'd1, op=11, dir=1 (left shift by 1), wr=1 -> SHL_RD.
- SHL_RD: noe=0, r_mcand<=i_aluY, r_mplr<=r_mplr>>1, r_cnt<=r_cnt+1 -> TEST.
- DONE: o_result<=r_acc, o_done=1 for exactly this cycle -> IDLE.
- Latency: i_start sampled in cycle 0; o_done high in cycle 23+2*popcount(i_b). The new o_result is visible from the cycle after o_done.
- Overflow: the product is truncated to 8 bits. Carry from ADD is discarded; no overflow flag.
- Boundaries and simultaneous events:
  - i_start while busy is ignored.
  - i_start in the DONE cycle is ignored, so a new op starts no earlier than the IDLE cycle after DONE.
  - i_abort in any non-IDLE state -> IDLE next cycle. No o_done pulse; o_result keeps its previous value.
  - i_abort together with i_start in IDLE: abort wins and nothing starts.
  - i_reset at any point, including mid-operation: all values return to reset values next cycle and no o_done pulse is emitted.

Optional Feature:
- Macro: MUL_EARLY_EXIT_EN.
- Defined: TEST goes to DONE whenever r_mplr==0, checked before the r_mplr[0] test. Latency = 1 + the states actually visited. Example: i_b=0 gives o_done in cycle 2; i_b=3 gives o_done in cycle 12.
- Undefined: all 8 bit-iterations always run, with the fixed latency above.

Test Plan:
- Reset mid-op: i_a=7, i_b=9, assert i_reset in cycle 5 -> next cycle IDLE, o_busy=0, o_aluNoe=1, o_result=0, no o_done.
- i_a=5, i_b=3 -> o_done in cycle 27, o_result=15. Exactly two ADD_EX and seven SHL_EX cycles; o_aluNoe is never low while o_aluWr=1.
- i_a=255, i_b=255 -> o_result=0x01, o_done in cycle 39. With MUL_EARLY_EXIT_EN the result is the same and o_done comes in cycle 39.
- i_a=0x10, i_b=0x10 -> o_result=0x00 (truncated). i_b=0 -> o_result=0, o_done in cycle 23 (cycle 2 with MUL_EARLY_EXIT_EN).
- i_start pulsed again in cycle 4 of 6x7 -> ignored, o_result=42. Then i_abort in cycle 3 of 2x2 -> IDLE, no o_done, o_result stays 42.
- Back-to-back: i_start held high continuously with 3x4 then 2x5 -> o_result 12 then 10. The second op is accepted only in the IDLE cycle after DONE.
